// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - Wishbone B4 classic single-transfer initiator with valid/ready command and response
// Optional bus timeout abort is enabled by defining WB_INIT_TIMEOUT_EN.
module wb_initiator #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_adr_i,
    input  logic [DATA_W-1:0]     req_dat_i,
    input  logic [DATA_W/8-1:0]   req_sel_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_dat_o,
    output logic                  rsp_err_o,

    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic [DATA_W-1:0]     wbm_dat_i
);

    localparam int SEL_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]    sel_q, sel_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;

    logic                timeout_hit;
    logic                bus_done;
    logic                bus_fail;

`ifdef WB_INIT_TIMEOUT_EN
    logic [15:0]         cnt_q, cnt_d;

    // Counter reads 0 in the first BUS cycle, so expiry is at TIMEOUT_CYCLES-1.
    assign timeout_hit = (state_q == S_BUS) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = 16'd0;
        if (state_q == S_BUS) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus_done = wbm_ack_i | wbm_err_i | timeout_hit;
    // A real ack or err in the expiry cycle wins over the timeout.
    assign bus_fail = wbm_err_i | (~wbm_ack_i & timeout_hit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid_i) state_d = S_BUS;
            S_BUS:  if (bus_done)    state_d = S_RESP;
            S_RESP: if (rsp_ready_i) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = req_we_i;
                    adr_d = req_adr_i;
                    dat_d = req_dat_i;
                    sel_d = req_sel_i;
                end
            end
            S_BUS: begin
                if (bus_done) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus_fail;
                    rsp_dat_d   = (bus_fail || we_q) ? '0 : wbm_dat_i;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
            end
        endcase
    end

    // Held low while reset is asserted so no command is taken during reset.
    assign req_ready_o = rst_ni && (state_q == S_IDLE);

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - self-checking bench for wb_initiator
module tb_wb_initiator;

    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_adr_i, req_dat_i;
    logic [3:0]  req_sel_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] wbm_dat_i;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_i = ~clk_i;

    wb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One command end to end. term_at: BUS cycle index where the responder answers (-1 = never).
    // kind: 0 ack, 1 err, 2 ack+err together.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int term_at, input int kind,
                        input logic [31:0] rdata, input int bp);
        int          n_cyc;
        logic        timed_out;
        logic        exp_err;
        logic [31:0] exp_dat;
`ifdef WB_INIT_TIMEOUT_EN
        timed_out = (term_at < 0) || (term_at >= TMO);
        n_cyc     = timed_out ? TMO : term_at + 1;
`else
        timed_out = 1'b0;
        n_cyc     = term_at + 1;
`endif
        exp_err = timed_out || (kind != 0);
        exp_dat = (exp_err || we) ? 32'h0 : rdata;

        chk("idle_ready", {31'b0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_we_i = ~we; req_adr_i = $urandom; req_dat_i = $urandom;
        req_sel_i = 4'($urandom);
        for (int k = 0; k < n_cyc; k++) begin
            chk("bus_cyc", {31'b0, wbm_cyc_o}, 32'd1);
            chk("bus_stb", {31'b0, wbm_stb_o}, 32'd1);
            chk("bus_we", {31'b0, wbm_we_o}, {31'b0, we});
            chk("bus_adr", wbm_adr_o, adr);
            chk("bus_dat", wbm_dat_o, dat);
            chk("bus_sel", {28'b0, wbm_sel_o}, {28'b0, sel});
            chk("bus_ready", {31'b0, req_ready_o}, 32'd0);
            chk("bus_rspv", {31'b0, rsp_valid_o}, 32'd0);
            if (k == term_at) begin
                wbm_ack_i = (kind != 1); wbm_err_i = (kind != 0); wbm_dat_i = rdata;
            end else begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
            end
            @(negedge clk_i);
        end
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
        chk("end_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("end_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
        chk("rsp_dat", rsp_dat_o, exp_dat);
        rsp_ready_i = 1'b0;
        for (int b = 0; b < bp; b++) begin
            wbm_ack_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            chk("bp_valid", {31'b0, rsp_valid_o}, 32'd1);
            chk("bp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
            chk("bp_dat", rsp_dat_o, exp_dat);
            chk("bp_ready", {31'b0, req_ready_o}, 32'd0);
            chk("bp_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        end
        wbm_ack_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("done_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("done_err", {31'b0, rsp_err_o}, 32'd0);
        chk("done_dat", rsp_dat_o, exp_dat);
        chk("done_ready", {31'b0, req_ready_o}, 32'd1);
    endtask

    initial begin
        logic        r_we;
        logic [31:0] r_adr, r_dat, r_rd;
        logic [3:0]  r_sel;

        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
        rsp_ready_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
        #2;
        chk("rst_ready", {31'b0, req_ready_o}, 32'd0);
        chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("rst_we", {31'b0, wbm_we_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
        chk("rst_rspv", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_rsperr", {31'b0, rsp_err_o}, 32'd0);
        chk("rst_rspdat", rsp_dat_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        xfer(1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 0, 0, 32'hDEAD_BEEF, 0);
        xfer(1'b0, 32'h3000_0010, 32'h5555_AAAA, 4'hF, 3, 0, 32'h1234_5678, 0);
        xfer(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1, 0, 32'h8765_4321, 5);
        xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 2, 32'hFFFF_0000, 1);
        xfer(1'b1, 32'h3000_0040, 32'h0BAD_CAFE, 4'h0, 2, 1, 32'h1111_1111, 0);

        wbm_ack_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        wbm_ack_i = 1'b0;
        chk("spur_rspv", {31'b0, rsp_valid_o}, 32'd0);
        chk("spur_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("spur_ready", {31'b0, req_ready_o}, 32'd1);

        req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h3000_0050; req_sel_i = 4'hF;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("mid_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("arst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("arst_ready", {31'b0, req_ready_o}, 32'd0);
        chk("arst_rspv", {31'b0, rsp_valid_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rel_ready", {31'b0, req_ready_o}, 32'd1);
        chk("rel_rspv", {31'b0, rsp_valid_o}, 32'd0);
        chk("rel_cyc", {31'b0, wbm_cyc_o}, 32'd0);

`ifdef WB_INIT_TIMEOUT_EN
        xfer(1'b0, 32'h3000_0060, 32'h0, 4'hF, -1, 0, 32'h0, 0);
        xfer(1'b0, 32'h3000_0064, 32'h0, 4'hF, TMO - 1, 0, 32'hAAAA_5555, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_adr = $urandom;
            r_dat = $urandom;
            r_sel = 4'($urandom);
            r_rd  = $urandom;
            xfer(r_we, r_adr, r_dat, r_sel, int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 2)), r_rd, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
